// File: rtl/apb_manager_pkg.sv
// Shared types for the APB manager: FSM state encoding and
// PPROT bit positions.
package apb_manager_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PROT_PRIV    = 3'b001;
    localparam logic [2:0] PROT_NONSEC  = 3'b010;
    localparam logic [2:0] PROT_INSTR   = 3'b100;

    // Counter width for a timeout of n cycles; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_manager_if.sv
// Request/response stream plus APB4 bus of the manager.
// master = manager side, slave = requester/subordinate side.
interface apb_manager_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int NumSubs   = 4
);
    localparam int StrbWidth = DataWidth / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_wdata;
    logic [StrbWidth-1:0] req_strb;
    logic [2:0]           req_prot;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_error;

    logic [NumSubs-1:0]   psel;
    logic                 penable;
    logic                 pwrite;
    logic [AddrWidth-1:0] paddr;
    logic [DataWidth-1:0] pwdata;
    logic [StrbWidth-1:0] pstrb;
    logic [2:0]           pprot;
    logic [DataWidth-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  req_strb, req_prot, rsp_ready,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output req_strb, req_prot, rsp_ready,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/apb_manager_addr_decode.sv
// Maps a byte address onto one of NumSubs equal regions.
// Out-of-range addresses yield dec_err and an all-zero select.
module apb_addr_decode #(
    parameter int          AddrWidth   = 32,
    parameter int          NumSubs     = 4,
    parameter int          SubAddrBits = 12,
    parameter int unsigned RegionBase  = 0
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [NumSubs-1:0]   sel,
    output logic                 dec_err
);

    localparam logic [AddrWidth-1:0] Base  = AddrWidth'(RegionBase);
    localparam logic [AddrWidth-1:0] Limit = AddrWidth'(NumSubs);

    logic [AddrWidth-1:0] offset;
    logic [AddrWidth-1:0] idx;

    // Full-width index compare so stray upper bits never alias a region.
    always_comb begin
        offset  = addr - Base;
        idx     = offset >> SubAddrBits;
        dec_err = (addr < Base) || (idx >= Limit);
        sel     = '0;
        for (int i = 0; i < NumSubs; i++) begin
            sel[i] = !dec_err && (idx == AddrWidth'(i));
        end
    end

endmodule

// File: rtl/apb_manager.sv
// Converts a valid/ready request stream into APB4 SETUP/ACCESS
// transfers and returns data/error on a valid/ready response.
module apb_manager
    import apb_manager_pkg::*;
#(
    parameter int          AddrWidth     = 32,
    parameter int          DataWidth     = 32,
    parameter int          NumSubs       = 4,
    parameter int          SubAddrBits   = 12,
    parameter int unsigned RegionBase    = 0,
    parameter int          TimeoutCycles = 16
) (
    input logic         clk,
    input logic         reset,
    apb_manager_if.master bus
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int CntW      = cnt_width(TimeoutCycles);
    localparam bit UseTmo    = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] CntLast =
        CntW'(UseTmo ? TimeoutCycles - 1 : 0);

    apb_state_e state;
    apb_state_e state_next;

    logic                 write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] strb_q;
    logic [2:0]           prot_q;
    logic [NumSubs-1:0]   sel_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q;
    logic [CntW-1:0]      cnt_q;

    logic [NumSubs-1:0]   dec_sel;
    logic                 dec_err;
    logic                 timeout;

    apb_addr_decode #(
        .AddrWidth   (AddrWidth),
        .NumSubs     (NumSubs),
        .SubAddrBits (SubAddrBits),
        .RegionBase  (RegionBase)
    ) u_decode (
        .addr    (bus.req_addr),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    assign timeout = UseTmo && (cnt_q == CntLast);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and bus outputs.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.psel      = '0;
        bus.penable   = 1'b0;
        bus.pwrite    = write_q;
        bus.paddr     = addr_q;
        bus.pwdata    = wdata_q;
        bus.pstrb     = write_q ? strb_q : '0;
        bus.pprot     = prot_q;
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = error_q;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = dec_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                bus.psel   = sel_q;
                state_next = ACCESS;
            end
            ACCESS: begin
                bus.psel    = sel_q;
                bus.penable = 1'b1;
                if (bus.pready || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, timeout counting and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        strb_q  <= bus.req_strb;
                        prot_q  <= bus.req_prot;
                        sel_q   <= dec_sel;
                        rdata_q <= '0;
                        error_q <= dec_err;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (bus.pready) begin
                        rdata_q <= write_q ? '0 : bus.prdata;
                        error_q <= bus.pslverr;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_manager.sv
// Scenario bench for apb_manager: expected responses are queued
// when a request is driven and compared when the response appears.
module tb_apb_manager;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   passed;
    exp_t sb[$];
    exp_t e;

    apb_manager_if #(.AddrWidth(32), .DataWidth(32), .NumSubs(4)) bus ();

    apb_manager #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .NumSubs       (4),
        .SubAddrBits   (12),
        .RegionBase    (0),
        .TimeoutCycles (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got hang, need finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.rsp_ready = 1'b1;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_strb  = s;
        bus.req_prot  = 3'b010;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        step();
        step();
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL reset_req_ready got %b need 1", bus.req_ready);
        else passed++;
        checks++;
        if ({bus.rsp_valid, bus.penable, bus.psel, bus.rsp_error} !== 7'b0)
            $display("FAIL reset_ctrl got %b need 0",
                     {bus.rsp_valid, bus.penable, bus.psel, bus.rsp_error});
        else passed++;
        checks++;
        if ({bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata} !== 100'b0)
            $display("FAIL reset_data got %h need 0",
                     {bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata});
        else passed++;
        step();
    endtask

    task automatic test_write();
        drive_req(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF);
        bus.pready = 1'b1;
        bus.prdata = 32'hAAAA5555;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        step();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite} !== 6'b0010_0_1)
            $display("FAIL wr_setup got %b need 001001",
                     {bus.psel, bus.penable, bus.pwrite});
        else passed++;
        checks++;
        if ({bus.paddr, bus.pwdata, bus.pstrb, bus.pprot} !==
            {32'h1004, 32'hDEADBEEF, 4'hF, 3'b010})
            $display("FAIL wr_bus got %h/%h/%h/%b need 1004/deadbeef/f/010",
                     bus.paddr, bus.pwdata, bus.pstrb, bus.pprot);
        else passed++;
        step();
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 6'b0010_1_0)
            $display("FAIL wr_access got %b need 001010",
                     {bus.psel, bus.penable, bus.rsp_valid});
        else passed++;
        step();
        checks++;
        if ({bus.rsp_valid, bus.psel, bus.penable, bus.req_ready} !== 7'b1_0000_0_0)
            $display("FAIL wr_resp_ctrl got %b need 1000000",
                     {bus.rsp_valid, bus.psel, bus.penable, bus.req_ready});
        else passed++;
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_rdata, bus.rsp_error} !== {e.rdata, e.err})
            $display("FAIL wr_resp got %h/%b need %h/%b",
                     bus.rsp_rdata, bus.rsp_error, e.rdata, e.err);
        else passed++;
        bus.pready = 1'b0;
        step();
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10)
            $display("FAIL wr_next_ready got %b need 10",
                     {bus.req_ready, bus.rsp_valid});
        else passed++;
    endtask

    task automatic test_wait_read();
        drive_req(1'b0, 32'h2008, 32'h11111111, 4'hF);
        bus.pready = 1'b0;
        sb.push_back('{rdata: 32'h12345678, err: 1'b0});
        step();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb} !== 10'b0100_0_0_0000)
            $display("FAIL rd_setup got %b need 0100000000",
                     {bus.psel, bus.penable, bus.pwrite, bus.pstrb});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.psel, bus.penable, bus.paddr, bus.pstrb, bus.rsp_valid} !==
                {4'b0100, 1'b1, 32'h2008, 4'h0, 1'b0})
                $display("FAIL rd_stable%0d got %b/%b/%h/%h/%b need 0100/1/2008/0/0",
                         i, bus.psel, bus.penable, bus.paddr, bus.pstrb,
                         bus.rsp_valid);
            else passed++;
            if (i == 3) begin
                bus.pready = 1'b1;
                bus.prdata = 32'h12345678;
            end
        end
        step();
        bus.pready = 1'b0;
        bus.prdata = 32'hFFFFFFFF;
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error} !== {1'b1, e.rdata, e.err})
            $display("FAIL rd_resp got %b/%h/%b need 1/%h/%b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.err);
        else passed++;
        step();
    endtask

    task automatic test_decode_map();
        logic [31:0] addrs [5] = '{32'h0, 32'h0FFC, 32'h3FFC, 32'h5000, 32'h80001000};
        logic [3:0]  sels  [5] = '{4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
        logic        errs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 32'hC0DE0000 + 32'(i);
            drive_req(1'b0, addrs[i], 32'h0, 4'h0);
            bus.pready = 1'b1;
            bus.prdata = d;
            sb.push_back('{rdata: errs[i] ? 32'h0 : d, err: errs[i]});
            step();
            bus.req_valid = 1'b0;
            if (!errs[i]) begin
                checks++;
                if (bus.psel !== sels[i])
                    $display("FAIL dec_sel%0d got %b need %b", i, bus.psel, sels[i]);
                else passed++;
                step();
                step();
            end
            checks++;
            if ({bus.rsp_valid, bus.psel, bus.penable} !== 6'b1_0000_0)
                $display("FAIL dec_resp_ctrl%0d got %b need 100000",
                         i, {bus.rsp_valid, bus.psel, bus.penable});
            else passed++;
            e = sb.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_error} !== {e.rdata, e.err})
                $display("FAIL dec_resp%0d got %h/%b need %h/%b",
                         i, bus.rsp_rdata, bus.rsp_error, e.rdata, e.err);
            else passed++;
            bus.pready = 1'b0;
            step();
        end
    endtask

    task automatic test_timeout();
        int n;
        drive_req(1'b0, 32'h3000, 32'h0, 4'h0);
        bus.pready = 1'b0;
        bus.prdata = 32'h5A5A5A5A;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        step();
        bus.req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!bus.penable) break;
            n++;
        end
        checks++;
        if (n !== 16)
            $display("FAIL tmo_cycles got %0d need 16", n);
        else passed++;
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.psel, bus.rsp_rdata, bus.rsp_error} !==
            {1'b1, 4'b0, e.rdata, e.err})
            $display("FAIL tmo_resp got %b/%b/%h/%b need 1/0000/%h/%b",
                     bus.rsp_valid, bus.psel, bus.rsp_rdata, bus.rsp_error,
                     e.rdata, e.err);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 32'h0010, 32'h01020304, 4'h3);
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.rsp_ready = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        step();
        drive_req(1'b0, 32'h1000, 32'h0, 4'h0);
        step();
        step();
        e = sb.pop_front();
        bus.pslverr = 1'b0;
        bus.prdata  = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.psel, bus.rsp_rdata, bus.rsp_error} !==
                {1'b1, 1'b0, 4'b0, e.rdata, e.err})
                $display("FAIL hold%0d got %b/%b/%b/%h/%b need 1/0/0000/%h/%b",
                         i, bus.rsp_valid, bus.req_ready, bus.psel,
                         bus.rsp_rdata, bus.rsp_error, e.rdata, e.err);
            else passed++;
            step();
        end
        bus.rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        step();
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10)
            $display("FAIL b2b_idle got %b need 10", {bus.req_ready, bus.rsp_valid});
        else passed++;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.psel, bus.pwrite} !== 5'b0010_0)
            $display("FAIL b2b_setup got %b need 00100", {bus.psel, bus.pwrite});
        else passed++;
        step();
        step();
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error} !== {1'b1, e.rdata, e.err})
            $display("FAIL b2b_resp got %b/%h/%b need 1/%h/%b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, e.rdata, e.err);
        else passed++;
        bus.pready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 32'h1000, 32'h0, 4'h0);
        bus.pready = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        step();
        bus.req_valid = 1'b0;
        step();
        checks++;
        if ({bus.penable, bus.psel} !== 5'b1_0010)
            $display("FAIL mid_access got %b need 10010", {bus.penable, bus.psel});
        else passed++;
        reset = 1'b1;
        step();
        sb.delete();
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready} !== 7'b0000_0_0_1)
            $display("FAIL mid_reset got %b need 0000001",
                     {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready});
        else passed++;
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        drive_idle();
        test_reset();
        test_write();
        test_wait_read();
        test_decode_map();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
